audio_frame_scheduler: RTL and testbench

Sample-rate scheduler between the Avalon-ST audio sources and the stereo DAC audio core. Once per sample period it fetches one sample from each required source and emits one stereo frame (left/right) on a ready/valid handshake. Sources are the tone generator (src0) and a second stream such as a FIFO-fed playback path (src1). It counts source underruns and sink overruns so the codec path can be checked in simulation and on the board.

---
 rtl/audio_frame_scheduler_if.sv | 42 ++++
 rtl/audio_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_scheduler_if.sv
// Stereo frame bus between the audio sources, the frame scheduler and the DAC audio core.
// The master side is the scheduler; the slave side is the surrounding source/sink logic.
interface audio_frame_scheduler_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] src0_data;
    logic              src0_valid;
    logic              src0_ready;
    logic [DATA_W-1:0] src1_data;
    logic              src1_valid;
    logic              src1_ready;
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  src0_data,
        input  src0_valid,
        output src0_ready,
        input  src1_data,
        input  src1_valid,
        output src1_ready,
        output left_data,
        output right_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output src0_data,
        output src0_valid,
        input  src0_ready,
        output src1_data,
        output src1_valid,
        input  src1_ready,
        input  left_data,
        input  right_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/audio_frame_scheduler.sv
// Sample-rate scheduler: once per sample period fetches the selected source samples and
// presents one stereo frame to the DAC core, counting source underruns and sink overruns.
module audio_frame_scheduler #(
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 1042,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    audio_frame_scheduler_if.master   audio,
    output logic                      tick,
    output logic [CNT_W-1:0]          underrun_count,
    output logic [CNT_W-1:0]          overrun_count
);
    localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        mode_q;
    logic              got0;
    logic              got1;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] right_q;
    logic              out_valid_q;

    logic need0;
    logic need1;
    logic ready0;
    logic ready1;
    logic take0;
    logic take1;
    logic frame_done;
    logic underrun_evt;
    logic overrun_evt;

    // Sample-period divider, free running whenever out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == TICK_LAST);

    assign need0 = (mode_q == 2'b00) || (mode_q == 2'b10);
    assign need1 = (mode_q == 2'b01) || (mode_q == 2'b10);

    assign ready0 = (state == FETCH) && need0 && !got0;
    assign ready1 = (state == FETCH) && need1 && !got1;
    assign take0  = ready0 && audio.src0_valid;
    assign take1  = ready1 && audio.src1_valid;

    // True when every needed channel is captured once this edge's transfers land.
    assign frame_done = (got0 || take0 || !need0) && (got1 || take1 || !need1);

    assign underrun_evt = (state == FETCH) && tick && !frame_done;
    assign overrun_evt  = (state == SEND) && tick;

    // Channel registers are zeroed at frame start, so an underrun leaves missing channels at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= '0;
            got0        <= 1'b0;
            got1        <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        mode_q  <= mode;
                        got0    <= 1'b0;
                        got1    <= 1'b0;
                        left_q  <= '0;
                        right_q <= '0;
                        if (mode == 2'b11) begin
                            state       <= SEND;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (take0) begin
                        got0   <= 1'b1;
                        left_q <= audio.src0_data;
                        if (mode_q != 2'b10) begin
                            right_q <= audio.src0_data;
                        end
                    end
                    if (take1) begin
                        got1    <= 1'b1;
                        right_q <= audio.src1_data;
                        if (mode_q != 2'b10) begin
                            left_q <= audio.src1_data;
                        end
                    end
                    if (frame_done || tick) begin
                        state       <= SEND;
                        out_valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (audio.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
            overrun_count  <= '0;
        end else begin
            if (underrun_evt && (underrun_count != '1)) begin
                underrun_count <= underrun_count + CNT_W'(1);
            end
            if (overrun_evt && (overrun_count != '1)) begin
                overrun_count <= overrun_count + CNT_W'(1);
            end
        end
    end

    assign audio.src0_ready = ready0;
    assign audio.src1_ready = ready1;
    assign audio.left_data  = left_q;
    assign audio.right_data = right_q;
    assign audio.out_valid  = out_valid_q;
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Self-checking bench for audio_frame_scheduler: vector table, corner-case sequences and
// a randomized run against a frame-level reference model.
module tb_audio_frame_scheduler;
    localparam int DATA_W = 16;
    localparam int TD     = 8;
    localparam int CNT_W  = 8;

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       mode   = 2'b00;
    logic             tick;
    logic [CNT_W-1:0] underrun_count;
    logic [CNT_W-1:0] overrun_count;

    audio_frame_scheduler_if #(.DATA_W(DATA_W)) bus ();

    audio_frame_scheduler #(
        .DATA_W   (DATA_W),
        .TICK_DIV (TD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .audio          (bus),
        .tick           (tick),
        .underrun_count (underrun_count),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] d0;
        logic [15:0] d1;
        int          dly0;
        int          dly1;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        int          exp_lat;
        int          exp_und;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Advances to the next cycle in which tick is high (strictly after the current one).
    task automatic wait_tick();
        for (int i = 0; i < 2 * TD + 2; i++) begin
            step();
            if (tick) return;
        end
        chk("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic idle_inputs();
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_rdy0"}, 32'(bus.src0_ready), 32'd0);
        chk({tag, "_rdy1"}, 32'(bus.src1_ready), 32'd0);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_left"}, 32'(bus.left_data), 32'd0);
        chk({tag, "_right"}, 32'(bus.right_data), 32'd0);
        chk({tag, "_und"}, 32'(underrun_count), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun_count), 32'd0);
    endtask

    // Reference model state (frame-level view).
    bit          m_gath;
    bit          m_pend;
    bit          m_got0;
    bit          m_got1;
    logic [1:0]  m_mq;
    logic [15:0] m_l;
    logic [15:0] m_r;
    int          m_und;
    int          m_ovr;
    int          m_cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          first_tick;
        int          first_ov;
        int          first_rdy;
        bit          e_tick;
        bit          n0;
        bit          n1;
        bit          e_r0;
        bit          e_r1;
        bit          t0;
        bit          t1;
        int unsigned vprob;

        vecs[0] = '{2'd0, 16'h1234, 16'hBEEF, 1,  1,  16'h1234, 16'h1234, 2, 0};
        vecs[1] = '{2'd2, 16'h0AAA, 16'h0555, 1,  4,  16'h0AAA, 16'h0555, 5, 0};
        vecs[2] = '{2'd1, 16'hFFFF, 16'h5A5A, 1,  2,  16'h5A5A, 16'h5A5A, 3, 0};
        vecs[3] = '{2'd3, 16'h1111, 16'h2222, 1,  1,  16'h0000, 16'h0000, 1, 0};
        vecs[4] = '{2'd2, 16'h8001, 16'h7FFE, 3,  1,  16'h8001, 16'h7FFE, 4, 0};
        vecs[5] = '{2'd0, 16'h0F0F, 16'h3333, 5,  1,  16'h0F0F, 16'h0F0F, 6, 0};
        vecs[6] = '{2'd1, 16'h4444, 16'h6666, 1,  99, 16'h0000, 16'h0000, 9, 1};
        vecs[7] = '{2'd2, 16'h4321, 16'h6789, 2,  99, 16'h4321, 16'h0000, 9, 2};

        bus.src0_data  = '0;
        bus.src1_data  = '0;
        idle_inputs();

        // Reset values and first tick / first frame timing after release.
        #2 reset = 1'b1;
        #1 chk_all_zero("rst");
        enable = 1'b1;
        mode = 2'd0;
        bus.src0_data = 16'h1234;
        bus.src0_valid = 1'b1;
        step();
        step();
        reset = 1'b0;
        first_tick = -1;
        first_ov = -1;
        for (int c = 0; c < TD + 5; c++) begin
            if (tick && first_tick < 0) first_tick = c;
            if (bus.out_valid && first_ov < 0) first_ov = c;
            step();
        end
        chk("first_tick_cycle", 32'(first_tick), 32'(TD - 1));
        chk("first_ovalid_cycle", 32'(first_ov), 32'(TD + 1));

        // Vector table: one frame per entry, latency measured from its tick.
        do_reset();
        idle_inputs();
        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].mode;
            bus.src0_data = vecs[v].d0;
            bus.src1_data = vecs[v].d1;
            wait_tick();
            lat = -1;
            for (int k = 1; k <= 12; k++) begin
                step();
                if (bus.out_valid) begin
                    lat = k;
                    break;
                end
                bus.src0_valid = (k >= vecs[v].dly0);
                bus.src1_valid = (k >= vecs[v].dly1);
            end
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("vec%0d_left", v), 32'(bus.left_data), 32'(vecs[v].exp_l));
            chk($sformatf("vec%0d_right", v), 32'(bus.right_data), 32'(vecs[v].exp_r));
            chk($sformatf("vec%0d_underrun", v), 32'(underrun_count), 32'(vecs[v].exp_und));
            chk($sformatf("vec%0d_overrun", v), 32'(overrun_count), 32'd0);
            bus.src0_valid = 1'b0;
            bus.src1_valid = 1'b0;
            step();
        end

        // Staggered sources in mode 10: ready lines per cycle.
        do_reset();
        idle_inputs();
        mode = 2'd2;
        bus.src0_data = 16'h0AAA;
        bus.src1_data = 16'h0555;
        wait_tick();
        step();
        chk("stag_t1_rdy0", 32'(bus.src0_ready), 32'd1);
        chk("stag_t1_rdy1", 32'(bus.src1_ready), 32'd1);
        bus.src0_valid = 1'b1;
        step();
        chk("stag_t2_rdy0", 32'(bus.src0_ready), 32'd0);
        chk("stag_t2_rdy1", 32'(bus.src1_ready), 32'd1);
        bus.src0_valid = 1'b0;
        step();
        chk("stag_t3_rdy1", 32'(bus.src1_ready), 32'd1);
        step();
        chk("stag_t4_ovalid", 32'(bus.out_valid), 32'd0);
        bus.src1_valid = 1'b1;
        step();
        chk("stag_t5_ovalid", 32'(bus.out_valid), 32'd1);
        chk("stag_t5_rdy1", 32'(bus.src1_ready), 32'd0);
        chk("stag_left", 32'(bus.left_data), 32'h0AAA);
        chk("stag_right", 32'(bus.right_data), 32'h0555);
        bus.src1_valid = 1'b0;
        step();

        // Backpressure: 20 stalled cycles cover two lost ticks, then exactly one handshake.
        do_reset();
        idle_inputs();
        mode = 2'd0;
        bus.src0_data = 16'h1234;
        bus.src0_valid = 1'b1;
        bus.out_ready = 1'b0;
        wait_tick();
        step();
        step();
        for (int j = 0; j < 20; j++) begin
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_left", 32'(bus.left_data), 32'h1234);
            chk("bp_hold_right", 32'(bus.right_data), 32'h1234);
            bus.src0_data = 16'($urandom);
            step();
        end
        chk("bp_overrun", 32'(overrun_count), 32'd2);
        chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
        bus.src0_data = 16'h1234;
        bus.out_ready = 1'b1;
        step();
        chk("bp_after_hs", 32'(bus.out_valid), 32'd0);
        step();
        chk("bp_resume_tick", 32'(tick), 32'd1);
        chk("bp_resume_t0", 32'(bus.out_valid), 32'd0);
        step();
        chk("bp_resume_t1", 32'(bus.out_valid), 32'd0);
        step();
        chk("bp_resume_t2", 32'(bus.out_valid), 32'd1);
        chk("bp_resume_left", 32'(bus.left_data), 32'h1234);
        chk("bp_overrun_final", 32'(overrun_count), 32'd2);
        chk("bp_underrun_final", 32'(underrun_count), 32'd0);

        // Mode switch 00 -> 11 while fetching: current frame keeps src0, next one is muted.
        do_reset();
        idle_inputs();
        mode = 2'd0;
        bus.src0_data = 16'h0C0C;
        wait_tick();
        step();
        chk("mute_t1_rdy0", 32'(bus.src0_ready), 32'd1);
        mode = 2'd3;
        step();
        step();
        bus.src0_valid = 1'b1;
        bus.src1_valid = 1'b1;
        step();
        chk("mute_cur_valid", 32'(bus.out_valid), 32'd1);
        chk("mute_cur_left", 32'(bus.left_data), 32'h0C0C);
        chk("mute_cur_right", 32'(bus.right_data), 32'h0C0C);
        wait_tick();
        step();
        chk("mute_next_valid", 32'(bus.out_valid), 32'd1);
        chk("mute_next_left", 32'(bus.left_data), 32'd0);
        chk("mute_next_right", 32'(bus.right_data), 32'd0);
        chk("mute_next_rdy0", 32'(bus.src0_ready), 32'd0);
        chk("mute_next_rdy1", 32'(bus.src1_ready), 32'd0);

        // Asynchronous reset with src1 captured and src0 pending.
        do_reset();
        idle_inputs();
        mode = 2'd2;
        bus.src0_data = 16'h0999;
        bus.src1_data = 16'h0777;
        bus.src1_valid = 1'b1;
        wait_tick();
        step();
        step();
        chk("rmid_rdy0_pending", 32'(bus.src0_ready), 32'd1);
        chk("rmid_rdy1_done", 32'(bus.src1_ready), 32'd0);
        #3 reset = 1'b1;
        #1 chk_all_zero("rmid");
        bus.src0_valid = 1'b1;
        step();
        reset = 1'b0;
        first_tick = -1;
        first_ov = -1;
        first_rdy = -1;
        for (int c = 0; c < TD + 5; c++) begin
            if (tick && first_tick < 0) first_tick = c;
            if (bus.out_valid && first_ov < 0) first_ov = c;
            if ((bus.src0_ready || bus.src1_ready) && first_rdy < 0) first_rdy = c;
            if (first_ov == c) begin
                chk("rmid_frame_left", 32'(bus.left_data), 32'h0999);
                chk("rmid_frame_right", 32'(bus.right_data), 32'h0777);
            end
            step();
        end
        chk("rmid_first_tick", 32'(first_tick), 32'(TD - 1));
        chk("rmid_first_ready", 32'(first_rdy), 32'(TD));
        chk("rmid_first_ovalid", 32'(first_ov), 32'(TD + 1));

        // Underrun: first missing frame, then saturation without wrap.
        do_reset();
        idle_inputs();
        mode = 2'd1;
        bus.src1_data = 16'h5555;
        wait_tick();
        for (int k = 0; k < TD + 1; k++) step();
        chk("und_first_valid", 32'(bus.out_valid), 32'd1);
        chk("und_first_left", 32'(bus.left_data), 32'd0);
        chk("und_first_right", 32'(bus.right_data), 32'd0);
        chk("und_first_count", 32'(underrun_count), 32'd1);
        for (int k = 0; k < 600 * TD; k++) step();
        chk("und_saturated", 32'(underrun_count), 32'd255);
        chk("und_no_overrun", 32'(overrun_count), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        idle_inputs();
        m_gath = 0;
        m_pend = 0;
        m_got0 = 0;
        m_got1 = 0;
        m_mq = 2'd0;
        m_l = '0;
        m_r = '0;
        m_und = 0;
        m_ovr = 0;
        m_cyc = 0;
        vprob = 4;
        for (int c = 0; c < 2000; c++) begin
            e_tick = ((m_cyc % TD) == TD - 1);
            n0 = (m_mq == 2'd0) || (m_mq == 2'd2);
            n1 = (m_mq == 2'd1) || (m_mq == 2'd2);
            e_r0 = m_gath && n0 && !m_got0;
            e_r1 = m_gath && n1 && !m_got1;
            chk("rnd_tick", 32'(tick), 32'(e_tick));
            chk("rnd_rdy0", 32'(bus.src0_ready), 32'(e_r0));
            chk("rnd_rdy1", 32'(bus.src1_ready), 32'(e_r1));
            chk("rnd_ovalid", 32'(bus.out_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rnd_left", 32'(bus.left_data), 32'(m_l));
                chk("rnd_right", 32'(bus.right_data), 32'(m_r));
            end
            chk("rnd_und", 32'(underrun_count), 32'(m_und));
            chk("rnd_ovr", 32'(overrun_count), 32'(m_ovr));

            if (e_tick) vprob = $urandom_range(0, 4);
            enable = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            bus.src0_data = 16'($urandom);
            bus.src1_data = 16'($urandom);
            bus.src0_valid = ($urandom_range(0, 3) < vprob);
            bus.src1_valid = ($urandom_range(0, 3) < vprob);
            bus.out_ready = ($urandom_range(0, 3) != 0);

            t0 = e_r0 && bus.src0_valid;
            t1 = e_r1 && bus.src1_valid;
            if (m_gath) begin
                if (t0) begin
                    m_got0 = 1;
                    m_l = bus.src0_data;
                    if (m_mq != 2'd2) m_r = bus.src0_data;
                end
                if (t1) begin
                    m_got1 = 1;
                    m_r = bus.src1_data;
                    if (m_mq != 2'd2) m_l = bus.src1_data;
                end
                if ((m_got0 || !n0) && (m_got1 || !n1)) begin
                    m_gath = 0;
                    m_pend = 1;
                end else if (e_tick) begin
                    if (m_und < 255) m_und++;
                    m_gath = 0;
                    m_pend = 1;
                end
            end else if (m_pend) begin
                if (e_tick && m_ovr < 255) m_ovr++;
                if (bus.out_ready) m_pend = 0;
            end else if (e_tick && enable) begin
                m_mq = mode;
                m_got0 = 0;
                m_got1 = 0;
                m_l = '0;
                m_r = '0;
                if (mode == 2'd3) m_pend = 1;
                else m_gath = 1;
            end
            m_cyc++;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
